// File: rtl/axis2fifo_pkg.sv
// Shared types and defaults for the axis2fifo receive bridge.
// Optional frame length counter is enabled with `define AXIS2FIFO_FRAME_LEN_EN.
package axis2fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned FRAME_LEN_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/axis2fifo_mem.sv
// Circular buffer: storage, wrap-around pointers, occupancy and registered read port.
// Writes are dropped when full; pops are dropped when empty.
module axis2fifo_mem
    import axis2fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  wr, rd;

    assign full_o  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr      = wr_en_i && !full_o;
    assign rd      = rd_en_i && !empty_o;

    // Pointer widths equal log2(DEPTH), so increments wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_WIDTH'(wr) - CNT_WIDTH'(rd);
        dout_d       = dout_q;
        dout_valid_d = rd;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage needs no reset; contents are only visible through counted reads.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign count_o      = count_q;

endmodule

// File: rtl/axis2fifo.sv
// AXI-Stream slave that buffers one frame per start into a FIFO and flags completion when drained.
// Define AXIS2FIFO_FRAME_LEN_EN to add the frame_len beat counter output.
module axis2fifo
    import axis2fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  m_axis_tdata,
    input  logic                   m_axis_tvalid,
    output logic                   m_axis_tready,
    input  logic                   m_axis_tlast,
    input  logic                   read,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   frame_done,
    output logic                   underflow
`ifdef AXIS2FIFO_FRAME_LEN_EN
    ,
    output logic [FRAME_LEN_W-1:0] frame_len
`endif
);

    state_e state_q, state_d;
    logic   frame_done_q, frame_done_d;
    logic   underflow_q, underflow_d;
    logic   beat_acc;

    // Ready depends only on registered state and occupancy, never on tvalid.
    assign m_axis_tready = (state_q == ST_RECV) && !full;
    assign beat_acc      = m_axis_tvalid && m_axis_tready;

    axis2fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (beat_acc),
        .wr_data_i    (m_axis_tdata),
        .rd_en_i      (read),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_comb begin
        state_d      = state_q;
        frame_done_d = frame_done_q;
        underflow_d  = underflow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RECV;
                    frame_done_d = 1'b0;
                    underflow_d  = 1'b0;
                end
            end
            ST_RECV: begin
                if (beat_acc && m_axis_tlast) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A pop on an empty buffer is reported even in the cycle start clears the flag.
        if (read && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;

`ifdef AXIS2FIFO_FRAME_LEN_EN
    logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;

    // Beats accepted in the current frame, saturating at all-ones.
    always_comb begin
        frame_len_d = frame_len_q;
        if (state_q == ST_IDLE && start) begin
            frame_len_d = '0;
        end else if (beat_acc && frame_len_q != '1) begin
            frame_len_d = frame_len_q + FRAME_LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_len_q <= '0;
        end else begin
            frame_len_q <= frame_len_d;
        end
    end

    assign frame_len = frame_len_q;
`endif

endmodule

// File: doc/axis2fifo.md
Name: axis2fifo

Overview:
- Receive-side companion to the transmit bridge: an AXI-Stream slave that accepts the HLS accelerator's result stream and buffers it in a circular FIFO.
- Results are presented to the host-side logic through a simple read/empty FIFO interface.
- Frame-aware: arms on `start`, captures beats until the `tlast` beat, then reports completion once the buffer has been drained.

Parameters:
- DATA_WIDTH, 32, width of stream data and FIFO words.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), derived localparam; pointer width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- start  in  1  arm reception of one frame; sampled in IDLE only.
- m_axis_tdata  in  DATA_WIDTH  result beat from accelerator.
- m_axis_tvalid  in  1  beat valid.
- m_axis_tready  out  1  beat accepted when tvalid && tready.
- m_axis_tlast  in  1  final beat of frame.
- read  in  1  pop request.
- dout  out  DATA_WIDTH  popped word, registered.
- dout_valid  out  1  one-cycle pulse: dout updated this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  ADDR_WIDTH+1  occupancy.
- frame_done  out  1  level: tlast accepted and FIFO drained.
- underflow  out  1  sticky: read while empty; cleared by reset or start.

Behaviour:
- Reset (rst == 0 at clk edge):
  - state = IDLE; pointers and count = 0.
  - dout = 0, dout_valid = 0, frame_done = 0, underflow = 0.
  - m_axis_tready = 0, empty = 1, full = 0.
  - Reset mid-frame discards buffered data; no further beats are accepted until the next start.
- m_axis_tready = (state == RECV) && !full. It is combinational from registered state/count only and never depends on tvalid.
- Write: on tvalid && tready, store mem[wr_ptr] = tdata; wr_ptr increments modulo DEPTH (wrap-around).
- Read: on read && !empty, the next cycle has dout = mem[rd_ptr] and dout_valid = 1; rd_ptr increments modulo DEPTH. Read latency is 1 cycle.
- Read while empty: no pointer change, dout holds its value, dout_valid = 0, underflow set.
- Simultaneous accept and pop: count unchanged; both pointers advance.
- Full with a pop in the same cycle: tready stays 0 that cycle and the beat is accepted the following cycle.
- States:
  - IDLE: tready = 0. On start, clear underflow and go to RECV. Writes are impossible here; reads are still serviced.
  - RECV: accept beats. When the accepted beat carries tlast, go to DRAIN. tready deasserts the following cycle.
  - DRAIN: tready = 0. When count == 0 and no write is pending, set frame_done = 1 and go to IDLE.
- frame_done stays high in IDLE until the next start, which clears it.
- start outside IDLE is ignored.
- Frames longer than DEPTH are legal: the reader drains concurrently and the stream is backpressured while full.
- A tlast beat arriving when full is held by the source until tready; it is not lost.
- tvalid while not in RECV: ignored (tready = 0).
- An empty frame cannot occur: tlast always comes with a beat.

Optional Feature:
- Macro: AXIS2FIFO_FRAME_LEN_EN.
- When defined:
  - Adds output frame_len [15:0], the number of beats accepted in the current frame.
  - Cleared on start and on reset; saturates at 16'hFFFF.
  - Holds its value after frame_done until the next start.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- axis2fifo_pkg:
  - state enum type (IDLE, RECV, DRAIN), 2 bits;
  - default DATA_WIDTH and DEPTH constants;
  - FRAME_LEN_W = 16.
- One sub-module, axis2fifo_mem: circular buffer holding the storage array, wr_ptr/rd_ptr/count, full/empty, and the registered dout/dout_valid.
- The top level holds the FSM, tready generation, frame_done, underflow and the optional frame_len.

Test Plan:
- Reset and basic frame: hold rst = 0 for 3 cycles and check all outputs are at their reset values. Then start; send 0x11, 0x22, 0x33, 0x44 with tlast on 0x44, no reads. Expect full = 1, count = 4, tready = 0. Pop 4 times: dout = 0x11..0x44, each with a dout_valid pulse; frame_done = 1 after the last pop.
- Backpressure and wrap-around: DEPTH = 4, frame of 10 beats (0x1..0xA), reading one word every 3 cycles. Expect tready to drop whenever full, all 10 words out in order, and pointers wrapping twice without corruption.
- Simultaneous accept and pop: with count = 2, tvalid and read in the same cycle. Expect count to stay 2 and both pointers to advance. With count = 4 and read, expect tready = 0 that cycle and the beat accepted the next cycle.
- Underflow and ignored inputs: read while empty in IDLE sets underflow = 1 and dout_valid = 0. tvalid in IDLE gives tready = 0 and nothing stored. A subsequent start clears underflow.
- Reset mid-frame: after 2 beats of a 4-beat frame, pull rst = 0 for 1 cycle. Expect count = 0, state IDLE, tready = 0, and the remaining beats not accepted until start.
- AXIS2FIFO_FRAME_LEN_EN build: a 7-beat frame gives frame_len = 7 at frame_done. The next start clears it to 0.
